// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer: FSM state encoding,
// next-PC select codes and the instruction word width.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Next-PC select codes, shared with the decoder's jump-kind encoding.
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_REG = 2'b01;
  localparam logic [1:0] PC_TGT = 2'b10;
  localparam logic [1:0] PC_RSV = 2'b11;

  // The reserved jump kind falls back to sequential/branch.
  function automatic logic [1:0] map_pc_sel(input logic [1:0] jump);
    return (jump == PC_RSV) ? PC_SEQ : jump;
  endfunction

endpackage

// File: rtl/fetch_wdog.sv
// -----------------------------------------------------------------------------
// fetch_wdog
// Wait-state watchdog for the instruction-memory request phase. Counts
// consecutive cycles without an ack (saturating at TIMEOUT) and raises a
// sticky error when a further ack-less cycle is seen at the saturation value.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_clear      ack seen this cycle: restart the wait count
//   i_count      requesting without ack this cycle
//   o_fetch_err  sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module fetch_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_fetch_err
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] r_wait_cnt;
  logic         r_fetch_err;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_fetch_err <= 1'b0;
    end else if (i_clear) begin
      r_wait_cnt <= '0;
    end else if (i_count) begin
      if (r_wait_cnt == W'(TIMEOUT)) begin
        r_fetch_err <= 1'b1;
      end else begin
        r_wait_cnt <= r_wait_cnt + W'(1);
      end
    end
  end

  assign o_fetch_err = r_fetch_err;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Multi-cycle control for the instruction-fetch datapath. Issues one memory
// request at a time, holds the returned word for decode under a valid/ready
// handshake, and on each consumed instruction pulses the PC write enable with
// the next-PC select and offset-add control.
//
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   o_imem_req        memory request (address is the current PC)
//   i_imem_ack        memory data valid, may coincide with o_imem_req
//   i_imem_rdata      instruction word, valid with i_imem_ack
//   o_ir_valid        o_ir_data holds an unconsumed instruction
//   o_ir_data         registered instruction word
//   i_ir_ready        decode accepts o_ir_data
//   i_dec_jump        jump kind: 00 seq/branch, 01 jr, 10 target, 11 reserved
//   i_dec_branch      conditional branch
//   i_dec_zero        ALU zero flag for the branch compare
//   i_dec_jal         jal (offset add)
//   o_pc_we           PC load enable, only in the handshake cycle
//   o_pc_sel          next-PC select
//   o_pc_take_off     add the sign-extended imm16 in the PC adder
//   o_fetch_err       sticky wait-state watchdog flag
//   o_instr_count     consumed-instruction count (wraps)
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               o_imem_req,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_ir_valid,
  output logic [INSTR_W-1:0] o_ir_data,
  input  logic               i_ir_ready,
  input  logic [1:0]         i_dec_jump,
  input  logic               i_dec_branch,
  input  logic               i_dec_zero,
  input  logic               i_dec_jal,
  output logic               o_pc_we,
  output logic [1:0]         o_pc_sel,
  output logic               o_pc_take_off,
  output logic               o_fetch_err,
  output logic [CNT_W-1:0]   o_instr_count
);

  state_t             r_state;
  logic               r_imem_req;
  logic               r_ir_valid;
  logic [INSTR_W-1:0] r_ir_data;
  logic [CNT_W-1:0]   r_instr_count;

  logic       w_handshake;
  logic [1:0] w_sel;
  logic       w_wd_clear;
  logic       w_wd_count;

  // Acks are only meaningful while requesting; elsewhere they are ignored.
  assign w_wd_clear = (r_state == ST_REQ) &  i_imem_ack;
  assign w_wd_count = (r_state == ST_REQ) & ~i_imem_ack;

  fetch_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_wd_clear),
    .i_count     (w_wd_count),
    .o_fetch_err (o_fetch_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_imem_req    <= 1'b0;
      r_ir_valid    <= 1'b0;
      r_ir_data     <= '0;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_REQ;
          r_imem_req <= 1'b1;
        end
        ST_REQ: begin
          if (i_imem_ack) begin
            r_ir_data  <= i_imem_rdata;
            r_ir_valid <= 1'b1;
            r_imem_req <= 1'b0;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (i_ir_ready) begin
            r_ir_valid    <= 1'b0;
            r_imem_req    <= 1'b1;
            r_instr_count <= r_instr_count + CNT_W'(1);
            r_state       <= ST_REQ;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_imem_req <= 1'b0;
          r_ir_valid <= 1'b0;
        end
      endcase
    end
  end

  // PC controls are combinational from the handshake so the PC loads at the
  // end of the consuming cycle; they stay quiet in every other cycle, which
  // keeps the request address stable for the whole REQ phase.
  assign w_handshake   = (r_state == ST_HOLD) & r_ir_valid & i_ir_ready;
  assign w_sel         = map_pc_sel(i_dec_jump);
  assign o_pc_we       = w_handshake;
  assign o_pc_sel      = w_handshake ? w_sel : PC_SEQ;
  assign o_pc_take_off = w_handshake & (w_sel == PC_SEQ) &
                         ((i_dec_branch & ~i_dec_zero) | i_dec_jal);

  assign o_imem_req    = r_imem_req;
  assign o_ir_valid    = r_ir_valid;
  assign o_ir_data     = r_ir_data;
  assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench: a transaction-level model (started / holding a word /
// ack-less wait streak / retired count) predicts every output each cycle,
// directed sequences pin the model with literal expectations, then a random
// phase exercises ack latency, backpressure, decode mixes and resets.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int TO = 4;
  localparam int CW = 6;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          ack   = 1'b0;
  logic [31:0]   rdata = '0;
  logic          ready = 1'b0;
  logic [1:0]    jump  = 2'b00;
  logic          br    = 1'b0;
  logic          zero  = 1'b0;
  logic          jal   = 1'b0;

  logic          o_imem_req;
  logic          o_ir_valid;
  logic [31:0]   o_ir_data;
  logic          o_pc_we;
  logic [1:0]    o_pc_sel;
  logic          o_pc_take_off;
  logic          o_fetch_err;
  logic [CW-1:0] o_instr_count;

  int n_pass  = 0;
  int n_total = 0;

  fetch_sequencer #(
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_imem_req    (o_imem_req),
    .i_imem_ack    (ack),
    .i_imem_rdata  (rdata),
    .o_ir_valid    (o_ir_valid),
    .o_ir_data     (o_ir_data),
    .i_ir_ready    (ready),
    .i_dec_jump    (jump),
    .i_dec_branch  (br),
    .i_dec_zero    (zero),
    .i_dec_jal     (jal),
    .o_pc_we       (o_pc_we),
    .o_pc_sel      (o_pc_sel),
    .o_pc_take_off (o_pc_take_off),
    .o_fetch_err   (o_fetch_err),
    .o_instr_count (o_instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one fetch at a time; a word is either held or not.
  // ---------------------------------------------------------------------------
  bit          m_started = 1'b0;
  bit          m_have    = 1'b0;
  logic [31:0] m_word    = '0;
  int          m_nowait  = 0;
  bit          m_err     = 1'b0;
  int unsigned m_count   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 1'b0;
      m_have    <= 1'b0;
      m_word    <= '0;
      m_nowait  <= 0;
      m_err     <= 1'b0;
      m_count   <= 0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (!m_have) begin
      if (ack) begin
        m_have   <= 1'b1;
        m_word   <= rdata;
        m_nowait <= 0;
      end else begin
        // Error once the ack-less streak exceeds TIMEOUT cycles.
        m_nowait <= m_nowait + 1;
        if (m_nowait + 1 > TO) m_err <= 1'b1;
      end
    end else if (ready) begin
      m_have  <= 1'b0;
      m_count <= m_count + 1;
    end
  end

  // Compare process: every cycle, at the falling edge.
  always @(negedge clk) begin
    bit         hs;
    logic [1:0] esel;
    bit         etake;
    hs    = m_have && ready;
    esel  = hs ? ((jump == 2'b11) ? 2'b00 : jump) : 2'b00;
    etake = hs && (esel == 2'b00) && ((br && !zero) || jal);
    check("imem_req",    o_imem_req,    m_started && !m_have);
    check("ir_valid",    o_ir_valid,    m_have);
    check("ir_data",     o_ir_data,     m_word);
    check("pc_we",       o_pc_we,       hs);
    check("pc_sel",      o_pc_sel,      esel);
    check("pc_take_off", o_pc_take_off, etake);
    check("fetch_err",   o_fetch_err,   m_err);
    check("instr_count", o_instr_count, m_count % (1 << CW));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed table for next-PC select: jump, branch, zero, jal -> sel, take.
  logic [1:0] t_jump [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11};
  logic       t_br   [5] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
  logic       t_zero [5] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
  logic       t_jal  [5] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
  logic [1:0] t_sel  [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
  logic       t_take [5] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0};

  initial begin
    int n_req;
    int n_we;
    int pct;

    #1 rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_imem_req", o_imem_req, 0);
    check("rst_ir_valid", o_ir_valid, 0);
    check("rst_ir_data",  o_ir_data, 0);
    check("rst_count",    o_instr_count, 0);
    check("rst_err",      o_fetch_err, 0);
    check("rst_pc_we",    o_pc_we, 0);

    // Zero-wait memory (ack follows req), ready held high.
    tick();
    ready = 1'b1;
    rst_n = 1'b1;
    ack   = o_imem_req;
    @(negedge clk);
    check("idle_no_req", o_imem_req, 0);
    n_we = 0;
    for (int k = 0; k < 11; k++) begin
      tick();
      ack = o_imem_req;
      @(negedge clk);
      if (k == 0) check("first_req", o_imem_req, 1);
      n_we += int'(o_pc_we);
    end
    check("five_pulses", n_we, 5);
    check("count_five",  o_instr_count, 5);
    n_req = int'(o_imem_req);

    // Ack delayed three cycles.
    #1;
    ack   = 1'b0;
    ready = 1'b0;
    n_we  = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 2) begin
        ack   = 1'b1;
        rdata = 32'h2002000A;
      end
      if (k == 3) ack = 1'b0;
      @(negedge clk);
      n_req += int'(o_imem_req);
      n_we  += int'(o_pc_we);
      if (k == 3) begin
        check("late_valid", o_ir_valid, 1);
        check("late_data",  o_ir_data, 32'h2002000A);
      end
    end
    check("req_cycles", n_req, 4);
    check("no_we_req",  n_we, 0);

    // Backpressure in HOLD, then release with a target jump.
    n_we = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("hold_valid", o_ir_valid, 1);
      check("hold_data",  o_ir_data, 32'h2002000A);
      n_we += int'(o_pc_we);
    end
    check("no_we_hold", n_we, 0);
    tick();
    ready = 1'b1;
    jump  = 2'b10;
    @(negedge clk);
    check("hs_we",   o_pc_we, 1);
    check("hs_sel",  o_pc_sel, 2'b10);
    check("hs_take", o_pc_take_off, 0);
    tick();
    ready = 1'b0;
    jump  = 2'b00;
    @(negedge clk);
    check("req_after_hs", o_imem_req, 1);
    check("we_after_hs",  o_pc_we, 0);
    check("count_six",    o_instr_count, 6);

    // Next-PC select per handshake.
    for (int i = 0; i < 5; i++) begin
      tick();
      ack   = 1'b1;
      rdata = $urandom;
      tick();
      ack   = 1'b0;
      jump  = t_jump[i];
      br    = t_br[i];
      zero  = t_zero[i];
      jal   = t_jal[i];
      ready = 1'b1;
      @(negedge clk);
      check("tbl_we",   o_pc_we, 1);
      check("tbl_sel",  o_pc_sel, t_sel[i]);
      check("tbl_take", o_pc_take_off, t_take[i]);
      tick();
      ready = 1'b0;
      jump  = 2'b00;
      br    = 1'b0;
      zero  = 1'b0;
      jal   = 1'b0;
    end

    // Watchdog: ack withheld.
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      @(negedge clk);
      if (k == 5) check("err_not_yet", o_fetch_err, 0);
      if (k == 6) check("err_set",     o_fetch_err, 1);
    end
    tick();
    ack   = 1'b1;
    ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("err_sticky", o_fetch_err, 1);

    // Reset in REQ with an ack arriving during reset.
    tick();
    ack   = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    @(negedge clk);
    check("pre_rst_req", o_imem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req_drop", o_imem_req, 0);
    ack   = 1'b1;
    rdata = 32'hDEADBEEF;
    tick();
    tick();
    @(negedge clk);
    check("rst_valid", o_ir_valid, 0);
    check("rst_count2", o_instr_count, 0);
    check("rst_err2",   o_fetch_err, 0);
    #1;
    rst_n = 1'b1;
    #1;
    check("idle_after_rel", o_imem_req, 0);
    @(negedge clk);
    check("restart_req",   o_imem_req, 1);
    check("restart_valid", o_ir_valid, 0);
    #1;
    ack = 1'b0;

    // Random phase.
    pct = 90;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 250 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 95;
          1:       pct = 50;
          default: pct = 3;
        endcase
      end
      ack   = ($urandom_range(0, 99) < pct);
      ready = $urandom_range(0, 1) != 0;
      jump  = 2'($urandom_range(0, 3));
      br    = $urandom_range(0, 1) != 0;
      zero  = $urandom_range(0, 1) != 0;
      jal   = $urandom_range(0, 3) == 0;
      rdata = $urandom;
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end
    tick();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "bench time limit");
  end

endmodule
